// File: rtl/sci_pkg.sv
// Shared definitions for the SCI master: FSM encoding, serial bit order and
// the smallest inter-frame gap the link tolerates.
package sci_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StAddr,
        StWdata,
        StWaitAck,
        StRdata,
        StDone,
        StGap
    } sci_state_e;

    // Address, write data and read data all travel MSB first.
    localparam bit SciMsbFirst = 1'b1;

    // DONE plus the IDLE accept cycle are the shortest possible CSN-high run.
    localparam int unsigned SciMinGap = 2;

    function automatic int unsigned sci_max(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sci_shift_reg.sv
// Loadable shift register shared by the TX (parallel load, serial out) and
// RX (serial in, parallel out) paths of the SCI master.
module sci_shift_reg
    import sci_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = SciMsbFirst
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic             shift_i,
    input  logic             serial_i,
    output logic [WIDTH-1:0] data_o,
    output logic             serial_o
);

    logic [WIDTH-1:0] data_q, data_d;

    // Load wins over shift; the serial input enters at the end opposite the output bit.
    always_comb begin
        data_d = data_q;
        if (load_i) begin
            data_d = load_data_i;
        end else if (shift_i) begin
            if (MSB_FIRST) begin
                data_d = (data_q << 1) | WIDTH'(serial_i);
            end else begin
                data_d = (data_q >> 1) | (WIDTH'(serial_i) << (WIDTH - 1));
            end
        end
    end

    // Register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o   = data_q;
    assign serial_o = MSB_FIRST ? data_q[WIDTH-1] : data_q[0];

endmodule

// File: rtl/sci_master.sv
// SCI master: turns native read/write requests into SCI frames and returns
// completion or read data. Define SCI_MASTER_TIMEOUT_EN to add an ACK
// watchdog that ends a stalled frame with RESP_ERR=1.
module sci_master
    import sci_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned GAP_CYCLES     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  REQ_VALID,
    output logic                  REQ_READY,
    input  logic                  REQ_WNR,
    input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic [DATA_WIDTH-1:0] REQ_WDATA,
    output logic                  RESP_VALID,
    output logic [DATA_WIDTH-1:0] RESP_RDATA,
    output logic                  RESP_ERR,
    output logic                  SCI_CSN,
    output logic                  SCI_REQ,
    input  logic                  SCI_RESP,
    input  logic                  SCI_ACK
);

    localparam int unsigned SW     = sci_max(ADDR_WIDTH, DATA_WIDTH);
    localparam int unsigned GapEff = sci_max(GAP_CYCLES, SciMinGap);
    localparam int unsigned CntW   = $clog2(sci_max(SW, GapEff)) + 1;

    localparam logic [CntW-1:0] AddrLast    = CntW'(ADDR_WIDTH - 1);
    localparam logic [CntW-1:0] DataLast    = CntW'(DATA_WIDTH - 1);
    // The first read bit is taken in WAIT_ACK, so RDATA counts one fewer.
    localparam logic [CntW-1:0] RdLast      = CntW'((DATA_WIDTH > 1) ? DATA_WIDTH - 2 : 0);
    localparam logic [CntW-1:0] GapLast     = CntW'(GapEff - 1);
    // DONE and the following IDLE cycle already count towards the gap.
    localparam logic [CntW-1:0] GapDoneLoad = CntW'(2);

    sci_state_e            state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  csn_q, csn_d, req_q, req_d;
    logic                  ack_q, resp_q;
    logic                  wnr_q, wnr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  timeout;

    logic                  tx_load, tx_shift, tx_bit;
    logic [SW-1:0]         tx_load_data, addr_aligned, wdata_aligned;
    logic                  rx_load, rx_shift;
    logic [DATA_WIDTH-1:0] rx_data;
    logic [SW-1:0]         unused_tx_data;
    logic                  unused_rx_serial;

    assign addr_aligned  = SciMsbFirst ? (SW'(REQ_ADDR) << (SW - ADDR_WIDTH)) : SW'(REQ_ADDR);
    assign wdata_aligned = SciMsbFirst ? (SW'(wdata_q) << (SW - DATA_WIDTH)) : SW'(wdata_q);

    sci_shift_reg #(
        .WIDTH     (SW),
        .MSB_FIRST (SciMsbFirst)
    ) u_tx_shift (
        .clk_i       (CLK),
        .rst_i       (RST),
        .load_i      (tx_load),
        .load_data_i (tx_load_data),
        .shift_i     (tx_shift),
        .serial_i    (1'b0),
        .data_o      (unused_tx_data),
        .serial_o    (tx_bit)
    );

    // RX register doubles as the RESP_RDATA holding register.
    sci_shift_reg #(
        .WIDTH     (DATA_WIDTH),
        .MSB_FIRST (SciMsbFirst)
    ) u_rx_shift (
        .clk_i       (CLK),
        .rst_i       (RST),
        .load_i      (rx_load),
        .load_data_i ('0),
        .shift_i     (rx_shift),
        .serial_i    (resp_q),
        .data_o      (rx_data),
        .serial_o    (unused_rx_serial)
    );

`ifdef SCI_MASTER_TIMEOUT_EN
    localparam int unsigned      WdW    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [WdW-1:0]   WdLast = WdW'(TIMEOUT_CYCLES - 1);

    logic [WdW-1:0] wd_q, wd_d;
    logic           err_q;

    assign timeout = ((state_q == StWaitAck) || (state_q == StRdata)) && (wd_q == WdLast);

    // Watchdog runs only while waiting on the slave; restarts on WAIT_ACK entry.
    always_comb begin
        wd_d = wd_q;
        if ((state_d == StWaitAck) && (state_q != StWaitAck)) begin
            wd_d = '0;
        end else if ((state_q == StWaitAck) || (state_q == StRdata)) begin
            wd_d = wd_q + 1'b1;
        end
    end

    // Error flag captured on the cycle that forces DONE.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= timeout;
        end
    end

    assign RESP_ERR = (state_q == StDone) && err_q;
`else
    // Keeps the parameter referenced when the watchdog is compiled out.
    localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;

    assign timeout  = 1'b0;
    assign RESP_ERR = 1'b0;
`endif

    // Next state, serial output bit and datapath controls for the frame sequencer.
    always_comb begin
        state_d      = state_q;
        wnr_d        = wnr_q;
        wdata_d      = wdata_q;
        req_d        = 1'b0;
        tx_load      = 1'b0;
        tx_load_data = '0;
        tx_shift     = 1'b0;
        rx_load      = 1'b0;
        rx_shift     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (REQ_VALID) begin
                    state_d      = StCmd;
                    wnr_d        = REQ_WNR;
                    wdata_d      = REQ_WDATA;
                    req_d        = REQ_WNR;
                    tx_load      = 1'b1;
                    tx_load_data = addr_aligned;
                end
            end
            StCmd: begin
                state_d  = StAddr;
                req_d    = tx_bit;
                tx_shift = 1'b1;
            end
            StAddr: begin
                if (cnt_q == AddrLast) begin
                    if (wnr_q) begin
                        // First data bit goes out now; the rest is preloaded one step ahead.
                        state_d      = StWdata;
                        req_d        = SciMsbFirst ? wdata_q[DATA_WIDTH-1] : wdata_q[0];
                        tx_load      = 1'b1;
                        tx_load_data = SciMsbFirst ? (wdata_aligned << 1) : (wdata_aligned >> 1);
                    end else begin
                        state_d = StWaitAck;
                    end
                end else begin
                    req_d    = tx_bit;
                    tx_shift = 1'b1;
                end
            end
            StWdata: begin
                if (cnt_q == DataLast) begin
                    state_d = StWaitAck;
                end else begin
                    req_d    = tx_bit;
                    tx_shift = 1'b1;
                end
            end
            StWaitAck: begin
                if (timeout) begin
                    state_d = StDone;
                    rx_load = 1'b1;
                end else if (ack_q) begin
                    if (wnr_q) begin
                        state_d = StDone;
                    end else begin
                        rx_shift = 1'b1;
                        state_d  = (DATA_WIDTH == 1) ? StDone : StRdata;
                    end
                end
            end
            StRdata: begin
                if (timeout) begin
                    state_d = StDone;
                    rx_load = 1'b1;
                end else if (ack_q) begin
                    rx_shift = 1'b1;
                    if (cnt_q == RdLast) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = (GapEff > 2) ? StGap : StIdle;
            end
            StGap: begin
                if (cnt_q == GapLast) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StGap;
            end
        endcase

        // Bit/gap counter restarts on every state change and never wraps inside a phase.
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = ((state_q == StDone) && (state_d == StGap)) ? GapDoneLoad : '0;
        end else if ((state_q == StAddr) || (state_q == StWdata) || (state_q == StGap) ||
                     ((state_q == StRdata) && rx_shift)) begin
            cnt_d = cnt_q + 1'b1;
        end

        csn_d = !((state_d == StCmd) || (state_d == StAddr) || (state_d == StWdata) ||
                  (state_d == StWaitAck) || (state_d == StRdata));
    end

    // State, captured request, registered SCI outputs and input resamplers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StGap;
            cnt_q   <= '0;
            csn_q   <= 1'b1;
            req_q   <= 1'b0;
            ack_q   <= 1'b0;
            resp_q  <= 1'b0;
            wnr_q   <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            csn_q   <= csn_d;
            req_q   <= req_d;
            ack_q   <= SCI_ACK;
            resp_q  <= SCI_RESP;
            wnr_q   <= wnr_d;
            wdata_q <= wdata_d;
        end
    end

    assign REQ_READY  = (state_q == StIdle);
    assign RESP_VALID = (state_q == StDone);
    assign RESP_RDATA = rx_data;
    assign SCI_CSN    = csn_q;
    assign SCI_REQ    = req_q;

endmodule

// File: tb/tb_sci_master.sv
// Directed bench for sci_master (8-bit address/data, GAP_CYCLES=2). The
// timeout scenario is built only with SCI_MASTER_TIMEOUT_EN defined.
module tb_sci_master;

    localparam int unsigned GAP = 2;
`ifdef SCI_MASTER_TIMEOUT_EN
    localparam int unsigned TO = 16;
`else
    localparam int unsigned TO = 1024;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       REQ_VALID = 1'b0;
    logic       REQ_READY;
    logic       REQ_WNR = 1'b0;
    logic [7:0] REQ_ADDR = '0;
    logic [7:0] REQ_WDATA = '0;
    logic       RESP_VALID;
    logic [7:0] RESP_RDATA;
    logic       RESP_ERR;
    logic       SCI_CSN;
    logic       SCI_REQ;
    logic       SCI_RESP = 1'b0;
    logic       SCI_ACK = 1'b0;

    int errors = 0;
    int checks = 0;

    sci_master #(
        .ADDR_WIDTH     (8),
        .DATA_WIDTH     (8),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .REQ_VALID  (REQ_VALID),
        .REQ_READY  (REQ_READY),
        .REQ_WNR    (REQ_WNR),
        .REQ_ADDR   (REQ_ADDR),
        .REQ_WDATA  (REQ_WDATA),
        .RESP_VALID (RESP_VALID),
        .RESP_RDATA (RESP_RDATA),
        .RESP_ERR   (RESP_ERR),
        .SCI_CSN    (SCI_CSN),
        .SCI_REQ    (SCI_REQ),
        .SCI_RESP   (SCI_RESP),
        .SCI_ACK    (SCI_ACK)
    );

    always #5 CLK = ~CLK;

    // Issues one request and plays the slave; cycle 1 is the CMD cycle.
    task automatic run_frame(
        input  logic        wnr,
        input  logic [7:0]  addr,
        input  logic [7:0]  wdata,
        input  logic [7:0]  rdata,
        input  int          ack_delay,
        input  int          stall_at,
        input  int          stall_len,
        output logic [16:0] req_bits,
        output int          n_low,
        output int          n_resp,
        output logic [7:0]  got_rdata,
        output logic        got_err,
        output int          resp_cyc,
        output int          last_ack_cyc
    );
        int   nbits, tx_done, k, bit_idx;
        logic ready_seen;
        nbits = wnr ? 17 : 9;
        req_bits = '0; n_low = 0; n_resp = 0; got_rdata = '0; got_err = 1'b0;
        resp_cyc = -1; last_ack_cyc = -1; tx_done = -1; bit_idx = 0;
        ready_seen = 1'b0;
        for (int i = 0; i < 50 && !ready_seen; i++) begin
            @(negedge CLK);
            ready_seen = REQ_READY;
        end
        if (!ready_seen) begin
            errors++; checks++;
            $display("FAIL ready_wait: REQ_READY=0 required 1 within 50 cycles");
        end
        REQ_VALID = 1'b1; REQ_WNR = wnr; REQ_ADDR = addr; REQ_WDATA = wdata;
        for (int cyc = 1; cyc <= 200 && !(n_resp > 0 && cyc > resp_cyc + 1); cyc++) begin
            @(negedge CLK);
            REQ_VALID = 1'b0;
            if (!SCI_CSN) begin
                if (n_low < nbits) req_bits = {req_bits[15:0], SCI_REQ};
                n_low++;
                if (n_low == nbits) tx_done = cyc;
            end
            if (RESP_VALID) begin
                n_resp++; got_rdata = RESP_RDATA; got_err = RESP_ERR; resp_cyc = cyc;
            end
            SCI_ACK = 1'b0; SCI_RESP = 1'b0;
            if (tx_done >= 0) begin
                k = cyc - tx_done - ack_delay;
                if (k >= 0) begin
                    if (wnr) begin
                        if (k == 0) begin
                            SCI_ACK = 1'b1; last_ack_cyc = cyc;
                        end
                    end else if (bit_idx < 8) begin
                        if (bit_idx == stall_at && k >= stall_at && k < stall_at + stall_len) begin
                            // Wrong data with ACK low must not be taken.
                            SCI_RESP = ~rdata[7 - bit_idx];
                        end else begin
                            SCI_ACK = 1'b1; SCI_RESP = rdata[7 - bit_idx];
                            bit_idx++; last_ack_cyc = cyc;
                        end
                    end
                end
            end
        end
        SCI_ACK = 1'b0; SCI_RESP = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge CLK);
        checks++;
        if ({SCI_CSN, SCI_REQ, REQ_READY, RESP_VALID, RESP_ERR} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_ctrl: csn,req,rdy,vld,err=%b required 10000",
                     {SCI_CSN, SCI_REQ, REQ_READY, RESP_VALID, RESP_ERR});
        end
        checks++;
        if (RESP_RDATA !== 8'h00) begin
            errors++; $display("FAIL reset_rdata: got %h required 00", RESP_RDATA);
        end
        RST = 1'b0;
        @(negedge CLK);
        checks++;
        if (REQ_READY !== 1'b0) begin
            errors++; $display("FAIL reset_gap1: REQ_READY=%b required 0", REQ_READY);
        end
        @(negedge CLK);
        checks++;
        if (REQ_READY !== 1'b1) begin
            errors++; $display("FAIL reset_gap2: REQ_READY=%b required 1", REQ_READY);
        end
    endtask

    task automatic test_read();
        logic [16:0] rb; int nl, nr, rc, la; logic [7:0] rd; logic er;
        run_frame(1'b0, 8'h12, 8'h00, 8'hC3, 1, 99, 0, rb, nl, nr, rd, er, rc, la);
        checks++;
        if (rb !== 17'h00012) begin
            errors++; $display("FAIL read_req_bits: got %h required 00012", rb);
        end
        checks++;
        if (nr !== 1 || rd !== 8'hC3) begin
            errors++; $display("FAIL read_data: pulses=%0d rdata=%h required 1 c3", nr, rd);
        end
        checks++;
        if (nl !== 18 || rc !== 19) begin
            errors++; $display("FAIL read_timing: csn_low=%0d resp_cyc=%0d required 18 19", nl, rc);
        end
    endtask

    task automatic test_write();
        logic [16:0] rb; int nl, nr, rc, la; logic [7:0] rd; logic er;
        run_frame(1'b1, 8'hA5, 8'h3C, 8'h00, 3, 99, 0, rb, nl, nr, rd, er, rc, la);
        checks++;
        if (rb !== 17'h1A53C) begin
            errors++; $display("FAIL write_req_bits: got %h required 1a53c", rb);
        end
        checks++;
        if (nl !== 21) begin
            errors++; $display("FAIL write_csn_low: got %0d required 21", nl);
        end
        checks++;
        if (nr !== 1 || er !== 1'b0 || rc !== 22) begin
            errors++;
            $display("FAIL write_resp: pulses=%0d err=%b cyc=%0d required 1 0 22", nr, er, rc);
        end
        checks++;
        if (rd !== 8'hC3) begin
            errors++; $display("FAIL write_rdata_hold: got %h required c3", rd);
        end
    endtask

    task automatic test_read_stall();
        logic [16:0] rb; int nl, nr, rc, la; logic [7:0] rd; logic er;
        run_frame(1'b0, 8'h34, 8'h00, 8'h5A, 1, 4, 2, rb, nl, nr, rd, er, rc, la);
        checks++;
        if (nr !== 1 || rd !== 8'h5A) begin
            errors++; $display("FAIL stall_data: pulses=%0d rdata=%h required 1 5a", nr, rd);
        end
        checks++;
        if (rc !== 21 || la !== 19) begin
            errors++; $display("FAIL stall_timing: resp_cyc=%0d last_ack=%0d required 21 19", rc, la);
        end
    endtask

    task automatic test_back_to_back();
        logic csn_log [1:40];
        int   n_resp, n_ready, bad_ready, low1, high1, low2, i;
        logic ready_seen;
        n_resp = 0; n_ready = 0; bad_ready = 0; low1 = 0; high1 = 0; low2 = 0;
        ready_seen = 1'b0;
        for (int w = 0; w < 50 && !ready_seen; w++) begin
            @(negedge CLK);
            ready_seen = REQ_READY;
        end
        checks++;
        if (!ready_seen) begin
            errors++; $display("FAIL b2b_ready_wait: REQ_READY=0 required 1");
        end
        SCI_ACK = 1'b1;
        REQ_VALID = 1'b1; REQ_WNR = 1'b1; REQ_ADDR = 8'h0F; REQ_WDATA = 8'hF0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge CLK);
            csn_log[c] = SCI_CSN;
            if (RESP_VALID) n_resp++;
            if (REQ_READY) n_ready++;
            if (!SCI_CSN && REQ_READY) bad_ready++;
            if (c == 40) begin
                REQ_VALID = 1'b0; SCI_ACK = 1'b0;
            end
        end
        i = 1;
        while (i <= 40 && !csn_log[i]) begin low1++; i++; end
        while (i <= 40 && csn_log[i]) begin high1++; i++; end
        while (i <= 40 && !csn_log[i]) begin low2++; i++; end
        checks++;
        if (low1 !== 18 || low2 !== 18) begin
            errors++; $display("FAIL b2b_frame_len: got %0d %0d required 18 18", low1, low2);
        end
        checks++;
        if (high1 !== GAP) begin
            errors++; $display("FAIL b2b_gap: csn high %0d cycles required %0d", high1, GAP);
        end
        checks++;
        if (bad_ready !== 0 || n_ready !== 2) begin
            errors++;
            $display("FAIL b2b_ready: busy_ready=%0d ready_cycles=%0d required 0 2", bad_ready, n_ready);
        end
        checks++;
        if (n_resp !== 2) begin
            errors++; $display("FAIL b2b_resp: got %0d pulses required 2", n_resp);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [16:0] rb; int nl, nr, rc, la, vld; logic [7:0] rd; logic er;
        vld = 0;
        @(negedge CLK);
        REQ_VALID = 1'b1; REQ_WNR = 1'b1; REQ_ADDR = 8'h77; REQ_WDATA = 8'h11;
        for (int c = 1; c <= 4; c++) begin
            @(negedge CLK);
            REQ_VALID = 1'b0;
        end
        checks++;
        if (SCI_CSN !== 1'b0) begin
            errors++; $display("FAIL rstmid_in_addr: SCI_CSN=%b required 0", SCI_CSN);
        end
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        checks++;
        if (SCI_CSN !== 1'b1) begin
            errors++; $display("FAIL rstmid_csn: SCI_CSN=%b required 1", SCI_CSN);
        end
        if (RESP_VALID) vld++;
        @(negedge CLK);
        if (RESP_VALID) vld++;
        checks++;
        if (REQ_READY !== 1'b0) begin
            errors++; $display("FAIL rstmid_gap: REQ_READY=%b required 0", REQ_READY);
        end
        @(negedge CLK);
        if (RESP_VALID) vld++;
        checks++;
        if (REQ_READY !== 1'b1 || vld !== 0) begin
            errors++;
            $display("FAIL rstmid_release: ready=%b resp_pulses=%0d required 1 0", REQ_READY, vld);
        end
        run_frame(1'b0, 8'h12, 8'h00, 8'h3C, 1, 99, 0, rb, nl, nr, rd, er, rc, la);
        checks++;
        if (nr !== 1 || rd !== 8'h3C || rb !== 17'h00012) begin
            errors++;
            $display("FAIL rstmid_next: pulses=%0d rdata=%h req=%h required 1 3c 00012", nr, rd, rb);
        end
    endtask

`ifdef SCI_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        logic [16:0] rb; int nl, nr, rc, la; logic [7:0] rd; logic er;
        run_frame(1'b0, 8'h55, 8'h00, 8'hFF, 1000, 99, 0, rb, nl, nr, rd, er, rc, la);
        checks++;
        if (nr !== 1 || er !== 1'b1 || rd !== 8'h00) begin
            errors++;
            $display("FAIL timeout_resp: pulses=%0d err=%b rdata=%h required 1 1 00", nr, er, rd);
        end
        checks++;
        if (rc !== 26 || nl !== 25) begin
            errors++; $display("FAIL timeout_timing: resp_cyc=%0d csn_low=%0d required 26 25", rc, nl);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_read();
        test_write();
        test_read_stall();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef SCI_MASTER_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sci_master.md
Name: sci_master

Overview:
- Initiator end of the SCI serial register link. Converts parallel native read/write requests into SCI frames on SCI_CSN/SCI_REQ and collects SCI_ACK/SCI_RESP from the SCI slave.
- Returns write completion, or read data, on a native response port.
- Sits on the host/test-controller side. Drives one SCI slave per instance.

Parameters:
- ADDR_WIDTH, 8, register address bits serialized per frame
- DATA_WIDTH, 8, register data bits per frame
- GAP_CYCLES, 2, minimum cycles SCI_CSN stays high between frames (must be >=2)
- TIMEOUT_CYCLES, 1024, ACK wait limit (used only with the optional feature)

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- REQ_VALID  in  1  native request valid
- REQ_READY  out  1  master can accept a request (IDLE only)
- REQ_WNR  in  1  1=write, 0=read
- REQ_ADDR  in  ADDR_WIDTH  register address
- REQ_WDATA  in  DATA_WIDTH  write data
- RESP_VALID  out  1  one-cycle completion pulse
- RESP_RDATA  out  DATA_WIDTH  read data, valid with RESP_VALID on reads
- RESP_ERR  out  1  timeout flag, valid with RESP_VALID (tied 0 without the optional feature)
- SCI_CSN  out  1  frame select, active low
- SCI_REQ  out  1  serial W/nR, address and write data
- SCI_RESP  in  1  serial read data from slave
- SCI_ACK  in  1  slave acknowledge / read-data qualifier

Behaviour:
- Reset:
  - SCI_CSN=1, SCI_REQ=0, REQ_READY=0 during reset, RESP_VALID=0, RESP_RDATA=0, RESP_ERR=0.
  - State goes to GAP with the counter loaded. REQ_READY rises GAP_CYCLES after reset release.
- SCI_ACK and SCI_RESP are resampled through one flop each before use.
- All SCI outputs are registered.
- Accept: the request is captured when REQ_VALID && REQ_READY. REQ_READY = (state==IDLE).
- States:
  - IDLE -> CMD on accept.
  - CMD: one cycle. SCI_CSN=0, SCI_REQ=captured WNR.
  - ADDR: ADDR_WIDTH cycles, SCI_REQ = address MSB first, bit count 0..ADDR_WIDTH-1. On the last bit, go to WDATA if write, else WAIT_ACK.
  - WDATA: DATA_WIDTH cycles, SCI_REQ = write data MSB first, then WAIT_ACK.
  - WAIT_ACK: SCI_REQ=0, SCI_CSN stays 0.
    - Write: the first sampled ACK=1 completes the frame -> DONE.
    - Read: the first sampled ACK=1 is also the first data bit -> RDATA.
  - RDATA: shift sampled SCI_RESP into the data register MSB first on every cycle with sampled ACK=1, until DATA_WIDTH bits are taken. Cycles with ACK=0 do not shift. Then -> DONE.
  - DONE: one cycle. RESP_VALID=1. RESP_RDATA = assembled word on reads, unchanged on writes. SCI_CSN returns to 1 here. -> GAP.
  - GAP: SCI_CSN=1 for GAP_CYCLES cycles, including the DONE cycle, then -> IDLE.
- SCI_CSN is low only in CMD, ADDR, WDATA, WAIT_ACK and RDATA.
- Write frame length on CSN low = 1 + ADDR_WIDTH + DATA_WIDTH + ACK latency.
- Counters:
  - One bit counter of width $clog2(max(ADDR_WIDTH,DATA_WIDTH))+1, cleared on each state entry.
  - No wrap-around within a phase.
- ACK seen in CMD, ADDR or WDATA is ignored.
- REQ_VALID while busy is held off. The request fields are captured at accept and are stable for the whole frame.
- RST asserted mid-frame: next cycle SCI_CSN=1, no RESP_VALID, GAP enforced. The slave sees a rising CSN and resyncs on the next falling edge.

Optional Feature:
- Macro: SCI_MASTER_TIMEOUT_EN.
- With the macro:
  - A watchdog counts cycles in WAIT_ACK and RDATA.
  - Reaching TIMEOUT_CYCLES forces DONE with RESP_ERR=1 and RESP_RDATA=0, then GAP.
  - The counter clears on entry to WAIT_ACK.
- Without the macro: no watchdog, RESP_ERR tied 0, and WAIT_ACK can hang indefinitely.

Decomposition:
- Shared package sci_pkg holds:
  - state encoding (IDLE, CMD, ADDR, WDATA, WAIT_ACK, RDATA, DONE, GAP)
  - SCI bit-order constant (MSB first)
  - minimum GAP value
- One natural sub-module: sci_shift_reg, a loadable shift register used for the TX address/data path (parallel load, MSB out) and RX data (serial in, parallel out).

Test Plan:
- Write, ADDR_WIDTH=8, DATA_WIDTH=8, addr 0xA5, data 0x3C, slave model ACKs 3 cycles after the last data bit:
  - SCI_REQ sequence 1,1010_0101,0011_1100.
  - CSN low 17 cycles plus ACK wait.
  - RESP_VALID one pulse, RESP_ERR=0.
- Read addr 0x12, slave returns 0xC3 with continuous ACK: RESP_RDATA=0xC3 and exactly 8 bits sampled.
- Read with ACK de-asserted for 2 cycles mid-word: RESP_RDATA still correct (0x5A) and bits are not duplicated.
- Back-to-back REQ_VALID held high: CSN high for exactly GAP_CYCLES between frames, and REQ_READY low throughout each frame.
- RST pulsed during the ADDR phase: CSN=1 on the next cycle, no RESP_VALID, and the following request completes normally.
- With SCI_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=16, slave never ACKs: RESP_VALID with RESP_ERR=1 and RESP_RDATA=0 exactly 16 cycles after entering WAIT_ACK.
